// File: rtl/flash_pkg.sv
// Shared constants and FSM state encoding for the SPI NOR flash read arbiter.
package flash_pkg;

  localparam int FLASH_ADDR_W = 24;

  localparam logic [7:0] FLASH_OP_READ      = 8'h03;
  localparam logic [7:0] FLASH_OP_FAST_READ = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_GAP   = 3'd5
  } flash_state_e;

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: divides clk into SCK, shifts MOSI out on falling
// edges and MISO in on rising edges. rise/fall are high in the clk cycle
// whose closing edge moves sck up/down, so the FSM can count bits on them.
module spi_bit_engine #(
  parameter int CLK_DIV = 2,
  parameter int SH_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            load,
  input  logic [SH_W-1:0] load_data,
  input  logic            sdi,
  output logic            sck,
  output logic            rise,
  output logic            fall,
  output logic            sdo_bit,
  output logic [7:0]      rx_next
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic [SH_W-1:0]  tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             tick;

  // Half-period divider, SCK toggle and the two shift registers.
  always_comb begin
    tick  = en && (div_q == DIV_LAST);
    rise  = tick && !sck_q;
    fall  = tick && sck_q;
    div_d = div_q;
    sck_d = sck_q;
    tx_d  = tx_q;
    rx_d  = rx_q;
    if (!en) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (tick) begin
      div_d = '0;
      sck_d = !sck_q;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (load) begin
      tx_d = load_data;
    end else if (fall) begin
      tx_d = {tx_q[SH_W-2:0], 1'b0};
    end
    if (rise) begin
      rx_d = {rx_q[6:0], sdi};
    end
  end

  // Engine registers; SCK parks low in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
      tx_q  <= '0;
      rx_q  <= '0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
    end
  end

  assign sck     = sck_q;
  assign sdo_bit = tx_q[SH_W-1];
  assign rx_next = {rx_q[6:0], sdi};

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin two-port read arbiter and sequencer for a single SPI NOR flash.
// Define FLASH_FAST_READ_EN to use opcode 0x0B with 8 dummy SCK cycles.
//
// Request handshake: reqN is held high until ackN; ackN is a one-cycle pulse
// on the cycle the request is latched (addrN/lenN captured at that edge).
// Read bytes return as one-cycle rvalidN pulses with rdata; doneN rides on
// the last rvalidN. There is no back-pressure on the return path.
import flash_pkg::*;

module flash_read_arbiter #(
  parameter int CLK_DIV = 2,
  parameter int LEN_W   = 8,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [23:0]      addr0,
  input  logic [23:0]      addr1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic             ack0,
  output logic             ack1,
  output logic [7:0]       rdata,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             cs_n,
  output logic             sck,
  output logic             sdo,
  input  logic             sdi,
  output logic             wp_n,
  output logic             hld_n,
  output logic [2:0]       dbg_state
);

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = FLASH_OP_FAST_READ;
  localparam bit         FAST   = 1'b1;
`else
  localparam logic [7:0] OPCODE = FLASH_OP_READ;
  localparam bit         FAST   = 1'b0;
`endif

  localparam int SH_W  = 8 + FLASH_ADDR_W;
  // GAP state lasts CS_GAP-1 cycles; the IDLE cycle makes up the rest.
  localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = (CS_GAP >= 2) ? GAP_W'(CS_GAP - 2) : '0;

  flash_state_e     state_q, state_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gnt_q, gnt_d;
  logic             prio_q, prio_d;
  logic             last_q, last_d;
  logic             cs_n_q, cs_n_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d;
  logic             rvalid_q, rvalid_d;
  logic             done_q, done_d;
  logic [7:0]       rdata_q, rdata_d;

  logic             eng_en, eng_load, eng_rise, eng_fall, eng_sdo;
  logic [SH_W-1:0]  eng_load_data;
  logic [7:0]       eng_rx_next;
  logic             sel1;

  assign eng_en = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                  (state_q == ST_DUMMY) || (state_q == ST_DATA);

  spi_bit_engine #(.CLK_DIV(CLK_DIV), .SH_W(SH_W)) u_engine (
    .clk       (clk),
    .reset     (reset),
    .en        (eng_en),
    .load      (eng_load),
    .load_data (eng_load_data),
    .sdi       (sdi),
    .sck       (sck),
    .rise      (eng_rise),
    .fall      (eng_fall),
    .sdo_bit   (eng_sdo),
    .rx_next   (eng_rx_next)
  );

  // Next-state logic: arbitration, bit/byte counting and output pulses.
  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    gap_d         = gap_q;
    gnt_d         = gnt_q;
    prio_d        = prio_q;
    last_d        = last_q;
    cs_n_d        = cs_n_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rvalid_d      = 1'b0;
    done_d        = 1'b0;
    rdata_d       = rdata_q;
    eng_load      = 1'b0;
    eng_load_data = {OPCODE, addr0};
    // prio_q=1 favours port 1; otherwise port 1 only wins if port 0 is idle.
    sel1          = prio_q ? req1 : !req0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d         = sel1;
          prio_d        = !sel1;
          ack0_d        = !sel1;
          ack1_d        = sel1;
          len_d         = sel1 ? len1 : len0;
          eng_load      = 1'b1;
          eng_load_data = {OPCODE, (sel1 ? addr1 : addr0)};
          cs_n_d        = 1'b0;
          bit_d         = '0;
          cnt_d         = '0;
          last_d        = 1'b0;
          state_d       = ST_CMD;
        end
      end
      ST_CMD, ST_ADDR: begin
        if (eng_fall) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) state_d = ST_ADDR;
          if (bit_q == 5'd31) begin
            bit_d   = '0;
            state_d = FAST ? ST_DUMMY : ST_DATA;
          end
        end
      end
      ST_DUMMY: begin
        if (eng_fall) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (eng_rise) begin
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d    = '0;
            rdata_d  = eng_rx_next;
            rvalid_d = 1'b1;
            cnt_d    = cnt_q + LEN_W'(1);
            // len 0 compares against all-ones, giving 2^LEN_W bytes.
            if (cnt_q == len_q - LEN_W'(1)) begin
              done_d = 1'b1;
              last_d = 1'b1;
            end
          end
        end
        if (eng_fall && last_q) begin
          cs_n_d  = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction without done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      gap_q    <= '0;
      gnt_q    <= 1'b0;
      prio_q   <= 1'b0;
      last_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      gap_q    <= gap_d;
      gnt_q    <= gnt_d;
      prio_q   <= prio_d;
      last_q   <= last_d;
      cs_n_q   <= cs_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign rvalid0   = rvalid_q && !gnt_q;
  assign rvalid1   = rvalid_q && gnt_q;
  assign done0     = done_q && !gnt_q;
  assign done1     = done_q && gnt_q;
  assign busy      = (state_q != ST_IDLE);
  assign cs_n      = cs_n_q;
  assign sdo       = eng_sdo && ((state_q == ST_CMD) || (state_q == ST_ADDR));
  assign wp_n      = 1'b1;
  assign hld_n     = 1'b1;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Directed bench for flash_read_arbiter with a behavioural SPI flash model.
`timescale 1ns/1ps
module tb_flash_read_arbiter;
  import flash_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int LEN_W   = 8;
  localparam int CS_GAP  = 4;
`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_OP = 8'h0B;
  localparam int DATA_START = 40;
  localparam int FAST_EXTRA = 8 * 2 * CLK_DIV;
`else
  localparam logic [7:0] EXP_OP = 8'h03;
  localparam int DATA_START = 32;
  localparam int FAST_EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             req0 = 1'b0, req1 = 1'b0;
  logic [23:0]      addr0 = '0, addr1 = '0;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic             ack0, ack1, rvalid0, rvalid1, done0, done1, busy;
  logic [7:0]       rdata;
  logic             cs_n, sck, sdo, wp_n, hld_n;
  logic             sdi = 1'b0;
  logic [2:0]       dbg_state;

  flash_read_arbiter #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .len0(len0), .len1(len1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .done0(done0), .done1(done1), .busy(busy),
    .cs_n(cs_n), .sck(sck), .sdo(sdo), .sdi(sdi),
    .wp_n(wp_n), .hld_n(hld_n), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Flash content: a fixed function of the byte address.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // ---------------- flash model (sampled between clk edges) ----------------
  logic        sck_prev = 1'b0;
  int          bit_n = 0;
  logic [31:0] cap = '0;
  int          sdo_bad = 0;
  always @(negedge clk) begin
    int idx;
    logic [7:0] b;
    if (cs_n) begin
      bit_n = 0;
      sdi   = 1'b0;
    end else if (sck && !sck_prev) begin
      if (bit_n < 32) cap = {cap[30:0], sdo};
      else if (sdo !== 1'b0) sdo_bad++;
      bit_n++;
    end else if (!sck && sck_prev && bit_n >= DATA_START) begin
      idx = bit_n - DATA_START;
      b   = flash_byte(cap[23:0] + 24'(idx / 8));
      sdi = b[7 - (idx % 8)];
    end
    sck_prev = sck;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit port, input int budget, output int waited);
    waited = 0;
    while (!(port ? ack1 : ack0) && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("ack%0d_seen", port), port ? ack1 : ack0, 1);
    check("other_ack_quiet", port ? ack0 : ack1, 0);
    check("cs_low_at_ack", cs_n, 0);
    check("busy_at_ack", busy, 1);
    if (port) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  // Called at the negedge where ack is visible; returns at the first
  // negedge with cs_n high again.
  task automatic run_body(input bit port, input logic [23:0] addr,
                          input logic [LEN_W-1:0] len, input int exp_cs_low);
    int cs_low = 1;
    int nbytes = 0;
    int ndone = 0;
    int done_at = -1;
    int nwrong = 0;
    int guard = 0;
    int bad0 = sdo_bad;
    int exp_n = (len == 0) ? (1 << LEN_W) : int'(len);
    while (guard < 20000) begin
      @(negedge clk);
      guard++;
      if (cs_n) break;
      cs_low++;
      if (port ? (rvalid0 || done0) : (rvalid1 || done1)) nwrong++;
      if (port ? rvalid1 : rvalid0) begin
        check($sformatf("rdata_p%0d_b%0d", port, nbytes), rdata, flash_byte(addr + 24'(nbytes)));
        nbytes++;
        if (port ? done1 : done0) begin
          ndone++;
          done_at = nbytes;
        end
      end else if (port ? done1 : done0) begin
        nwrong++;
      end
    end
    check("txn_finished", cs_n, 1);
    check("cs_low_cycles", cs_low, exp_cs_low + FAST_EXTRA);
    check("byte_count", nbytes, exp_n);
    check("done_count", ndone, 1);
    check("done_on_last", done_at, exp_n);
    check("wrong_port_strobes", nwrong, 0);
    check("opcode", cap[31:24], EXP_OP);
    check("address", cap[23:0], addr);
    check("sdo_low_after_addr", sdo_bad - bad0, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("idle_after_gap", busy, 0);
    check("sck_idle_low", sck, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               port;
    logic [23:0]      addr;
    logic [LEN_W-1:0] len;
    int               exp_cs_low;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int w;
    int seen;
    vecs[0] = '{port: 1'b0, addr: 24'h000100, len: 8'd4, exp_cs_low: 256};
    vecs[1] = '{port: 1'b1, addr: 24'h123456, len: 8'd1, exp_cs_low: 160};
    vecs[2] = '{port: 1'b0, addr: 24'hFFFFFE, len: 8'd3, exp_cs_low: 224};
    vecs[3] = '{port: 1'b1, addr: 24'hABCDEF, len: 8'd2, exp_cs_low: 192};
    vecs[4] = '{port: 1'b1, addr: 24'h00F000, len: 8'd0, exp_cs_low: 8320};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_sdo", sdo, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack0, ack1}, 0);
    check("rst_rvalid_done", {rvalid0, rvalid1, done0, done1}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_wp_hld", {wp_n, hld_n}, 2'b11);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single-port transactions
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].port) begin
        req1 = 1'b1; addr1 = vecs[i].addr; len1 = vecs[i].len; addr0 = ~vecs[i].addr;
      end else begin
        req0 = 1'b1; addr0 = vecs[i].addr; len0 = vecs[i].len; addr1 = ~vecs[i].addr;
      end
      wait_ack(vecs[i].port, 20, w);
      check($sformatf("ack_latency_v%0d", i), w, 1);
      run_body(vecs[i].port, vecs[i].addr, vecs[i].len, vecs[i].exp_cs_low);
      wait_idle();
    end

    // Reset during the second data byte
    req0 = 1'b1; addr0 = 24'h000200; len0 = 8'd4;
    wait_ack(0, 20, w);
    seen = 0;
    while (!rvalid0 && seen < 400) begin
      @(negedge clk);
      seen++;
    end
    check("abort_first_byte_seen", rvalid0, 1);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_busy", busy, 0);
    check("abort_sck", sck, 0);
    check("abort_sdo", sdo, 0);
    check("abort_strobes", {rvalid0, done0, ack0, ack1}, 0);
    check("abort_rdata", rdata, 0);
    check("abort_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done0 || rvalid0 || !cs_n) seen++;
    end
    check("abort_no_done", seen, 0);

    // Both ports at once after reset: port 0 first, then port 1, with
    // port 0 re-requesting during its own transaction.
    req0 = 1'b1; addr0 = 24'h0A0B0C; len0 = 8'd2;
    req1 = 1'b1; addr1 = 24'h300000; len1 = 8'd3;
    wait_ack(0, 20, w);
    check("both_req_p0_latency", w, 1);
    req0 = 1'b1; addr0 = 24'h0000F0; len0 = 8'd1;
    run_body(0, 24'h0A0B0C, 8'd2, 192);
    wait_ack(1, 50, w);
    check("gap_to_p1_ack", w, CS_GAP);
    run_body(1, 24'h300000, 8'd3, 224);
    wait_ack(0, 50, w);
    check("gap_to_p0_ack", w, CS_GAP);
    run_body(0, 24'h0000F0, 8'd1, 160);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
